frb_dedisp_trigger: RTL
=======================

// Module: frb_dedisp_trigger
// PURPOSE
//  Receive end of the dedispersor framed stream (samples with sof/eof, plus per-frame integrated power).
//  Checks frame structure, tracks an EMA baseline of good-frame power and pulses a trigger when a
//  frame's power exceeds baseline*thresh. Sits after dedisp_top; feeds the capture/readout logic.
// PARAMETERS
//  N_CHANNELS  64  samples per frame; >=4 (guarantees >=4 cycles between integ_valid pulses)
//  DIN_WIDTH   26  sample width (only valid/sof/eof are inspected)
//  AVG_SHIFT   6   EMA weight 2^-AVG_SHIFT
//  WARMUP      64  good frames absorbed into baseline before triggering is allowed
//  HOLDOFF     128 good frames after a trigger during which no new trigger fires
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  ce           in   1   clock enable; low = every register holds
//  din          in   DIN_WIDTH  dedispersed sample (unused, kept for interface symmetry)
//  din_valid    in   1   sample valid
//  din_sof      in   1   first sample of frame (coincides with din_valid)
//  din_eof      in   1   last sample of frame (coincides with din_valid)
//  integ_pow    in   32  frame power, unsigned
//  integ_valid  in   1   frame power valid, 1 cycle after din_eof
//  thresh       in   8   threshold multiplier, unsigned Q4.4 (0x30 = 3.0); sampled at stage 1
//  trigger      out  1   1-cycle pulse: frame exceeded threshold
//  trig_pow     out  32  integ_pow of last triggering frame
//  trig_frame   out  32  good-frame index of last triggering frame (0-based, wraps)
//  baseline     out  32  current EMA baseline
//  frame_err    out  1   1-cycle pulse per structural error
//  err_count    out  16  structural errors, saturates at 0xFFFF
//  state_o      out  2   0=WARMUP 1=ARMED 2=HOLDOFF
// BEHAVIOUR
//  Reset: all outputs 0, state WARMUP, sample/frame/warmup/holdoff counters 0, in_frame=0, ok_flag=0.
//  Frame checker (per ce cycle, registered, frame_err 1 cycle after offending input):
//   - sof with valid: error if in_frame (counted once; restarts frame), else in_frame=1, cnt=1.
//   - valid without sof/eof: error if !in_frame; else cnt++.
//   - eof: error if !in_frame or cnt+1 != N_CHANNELS; else ok_flag=1. in_frame=0 either way.
//   - sof&eof same cycle: legal only if N_CHANNELS==1 (never), so error.
//   - any error clears ok_flag.
//  integ_valid with ok_flag=0: dropped, no error; with ok_flag=1: consumed, ok_flag cleared.
//  Pipeline (consumed frames only): stage1 registers lhs={integ_pow,4'b0} (36b, zero-ext 40b),
//   rhs=baseline*thresh (40b); stage2 (2 cycles after integ_valid) over=(lhs>rhs), then:
//   - WARMUP: no trigger; first frame after reset loads baseline=pow, later frames do EMA;
//     after WARMUP frames -> ARMED.
//   - ARMED: over -> trigger=1, trig_pow/trig_frame load, baseline unchanged, holdoff cnt=0,
//     -> HOLDOFF; !over -> EMA update.
//   - HOLDOFF: over -> no trigger, baseline unchanged; !over -> EMA; every consumed frame
//     increments holdoff cnt; at HOLDOFF -> ARMED.
//  EMA: baseline <= baseline + (pow>>AVG_SHIFT) - (baseline>>AVG_SHIFT), truncating, 32b, no overflow.
//  Comparison always uses baseline before this frame's update. frame index increments per consumed frame.
//  thresh=0 with ARMED: any nonzero pow triggers. Reset mid-frame/mid-holdoff: full reset, state WARMUP.
//  ce low: outputs hold, trigger/frame_err hold their registered value (pulses resume on next ce).
// TESTING
//  1 64 well-formed frames pow=1000 -> baseline=1000, state ARMED, no trigger, err_count=0.
//  2 ARMED, thresh=0x30, base 1000: pow=3001 -> trigger 2 cycles after integ_valid, trig_pow=3001,
//    trig_frame=64, baseline stays 1000; pow=3000 instead -> no trigger, baseline stays 1000.
//  3 After trigger, pow=5000 on next 127 frames -> no trigger; 128th good frame rearms; next 5000 triggers.
//  4 Frame with eof after 63 samples -> frame_err pulse, err_count=1, following integ_valid ignored.
//  5 sof inside frame, valid outside frame -> 2 errors counted; 0xFFFF errors -> saturates.
//  6 rst mid-HOLDOFF -> all outputs 0, state WARMUP; ce=0 for 10 cycles mid-frame -> no state change.

Source files
------------

// File: rtl/frb_dedisp_trigger_if.sv
// Stream interface between the dedispersor output and the trigger block.
// Valid-only streaming, no backpressure: a sample counts on any ce cycle with din_valid=1, a frame power on any ce cycle with integ_valid=1.
interface frb_dedisp_trigger_if #(
    parameter int DIN_WIDTH = 26
) ();
    logic                 ce;
    logic [DIN_WIDTH-1:0] din;
    logic                 din_valid;
    logic                 din_sof;
    logic                 din_eof;
    logic [31:0]          integ_pow;
    logic                 integ_valid;
    logic [7:0]           thresh;

    logic                 trigger;
    logic [31:0]          trig_pow;
    logic [31:0]          trig_frame;
    logic [31:0]          baseline;
    logic                 frame_err;
    logic [15:0]          err_count;
    logic [1:0]           state_o;

    modport master (
        output ce, din, din_valid, din_sof, din_eof, integ_pow, integ_valid, thresh,
        input  trigger, trig_pow, trig_frame, baseline, frame_err, err_count, state_o
    );

    modport slave (
        input  ce, din, din_valid, din_sof, din_eof, integ_pow, integ_valid, thresh,
        output trigger, trig_pow, trig_frame, baseline, frame_err, err_count, state_o
    );
endinterface

// File: rtl/frb_dedisp_trigger.sv
// Frame-structure checker plus EMA-baseline power trigger for the dedispersed stream.
// Sample width (DIN_WIDTH) is carried by the interface; sample contents are never inspected.
module frb_dedisp_trigger #(
    parameter int N_CHANNELS = 64,
    parameter int AVG_SHIFT  = 6,
    parameter int WARMUP     = 64,
    parameter int HOLDOFF    = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    frb_dedisp_trigger_if.slave  bus
);
    localparam int CNT_W  = $clog2(N_CHANNELS + 1);
    localparam int WARM_W = $clog2(WARMUP + 1);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [1:0] ST_WARMUP  = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    logic              in_frame;
    logic [CNT_W-1:0]  cnt;
    logic              ok_flag;
    logic              frame_err_q;
    logic [15:0]       err_count_q;

    logic              s1_valid;
    logic [39:0]       s1_lhs;
    logic [39:0]       s1_rhs;
    logic [31:0]       s1_pow;

    logic [1:0]        state;
    logic [WARM_W-1:0] warm_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [31:0]       frame_idx;
    logic [31:0]       baseline_q;
    logic [31:0]       trig_pow_q;
    logic [31:0]       trig_frame_q;
    logic              trigger_q;

    logic              err;
    logic              in_frame_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              ok_n;
    logic              consume;
    logic              over;
    logic [31:0]       ema;

    // Structural check; cnt saturates at N_CHANNELS so overlong frames still fail at eof.
    always_comb begin
        err        = 1'b0;
        in_frame_n = in_frame;
        cnt_n      = cnt;
        ok_n       = ok_flag;
        if (bus.integ_valid && ok_flag) ok_n = 1'b0;
        if (bus.din_valid) begin
            if (bus.din_sof && bus.din_eof) begin
                err        = 1'b1;
                in_frame_n = 1'b0;
            end else if (bus.din_sof) begin
                err        = in_frame;
                in_frame_n = 1'b1;
                cnt_n      = CNT_W'(1);
            end else if (bus.din_eof) begin
                in_frame_n = 1'b0;
                if (!in_frame || cnt != CNT_W'(N_CHANNELS - 1)) err = 1'b1;
                else                                            ok_n = 1'b1;
            end else if (!in_frame) begin
                err = 1'b1;
            end else if (cnt != CNT_W'(N_CHANNELS)) begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
        if (err) ok_n = 1'b0;
    end

    assign consume = bus.integ_valid && ok_flag;
    assign over    = s1_lhs > s1_rhs;
    // Subtract first so the intermediate never exceeds 32 bits.
    assign ema     = (baseline_q - (baseline_q >> AVG_SHIFT)) + (s1_pow >> AVG_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame     <= 1'b0;
            cnt          <= '0;
            ok_flag      <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
            s1_valid     <= 1'b0;
            s1_lhs       <= '0;
            s1_rhs       <= '0;
            s1_pow       <= '0;
            state        <= ST_WARMUP;
            warm_cnt     <= '0;
            hold_cnt     <= '0;
            frame_idx    <= '0;
            baseline_q   <= '0;
            trig_pow_q   <= '0;
            trig_frame_q <= '0;
            trigger_q    <= 1'b0;
        end else if (bus.ce) begin
            in_frame    <= in_frame_n;
            cnt         <= cnt_n;
            ok_flag     <= ok_n;
            frame_err_q <= err;
            if (err && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;

            s1_valid <= consume;
            if (consume) begin
                s1_lhs <= {4'b0, bus.integ_pow, 4'b0};
                s1_rhs <= 40'(baseline_q) * 40'(bus.thresh);
                s1_pow <= bus.integ_pow;
            end

            trigger_q <= 1'b0;
            if (s1_valid) begin
                frame_idx <= frame_idx + 32'd1;
                case (state)
                    ST_WARMUP: begin
                        baseline_q <= (warm_cnt == '0) ? s1_pow : ema;
                        warm_cnt   <= warm_cnt + WARM_W'(1);
                        if (warm_cnt == WARM_W'(WARMUP - 1)) state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (over) begin
                            trigger_q    <= 1'b1;
                            trig_pow_q   <= s1_pow;
                            trig_frame_q <= frame_idx;
                            hold_cnt     <= '0;
                            state        <= ST_HOLDOFF;
                        end else begin
                            baseline_q <= ema;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (!over) baseline_q <= ema;
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        if (hold_cnt == HOLD_W'(HOLDOFF - 1)) state <= ST_ARMED;
                    end
                    default: state <= ST_WARMUP;
                endcase
            end
        end
    end

    assign bus.trigger    = trigger_q;
    assign bus.trig_pow   = trig_pow_q;
    assign bus.trig_frame = trig_frame_q;
    assign bus.baseline   = baseline_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.state_o    = state;
endmodule
